// File: rtl/neokeon_pkg.sv
// Noekeon shared definitions: round-constant schedule, step functions, FSM states.
// Decrypt support is enabled by defining NEOKEON_DECRYPT_EN.
package neokeon_pkg;

  localparam logic [7:0] NEOKEON_RC_INIT = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] theta_mix(input logic [31:0] x);
    return x ^ rotl32(x, 8) ^ rotl32(x, 24);
  endfunction

  // Word a[0] occupies bits 127:96, a[3] bits 31:0.
  function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = theta_mix(a0 ^ a2);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    {a0, a1, a2, a3} = {a0, a1, a2, a3} ^ k;
    t  = theta_mix(a1 ^ a3);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {s[127:96], rotl32(s[95:64], 31), rotl32(s[63:32], 27), rotl32(s[31:0], 30)};
  endfunction

  function automatic logic [7:0] rc_next(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] rc_prev(input logic [7:0] rc);
    return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
  endfunction

  function automatic logic [7:0] rc_at(input int unsigned n);
    logic [7:0] rc;
    rc = NEOKEON_RC_INIT;
    for (int unsigned i = 0; i < n; i++) rc = rc_next(rc);
    return rc;
  endfunction

endpackage

// File: rtl/neokeon_round_fn.sv
// Combinational Noekeon round: constant add + Theta (order depends on mode),
// then Pi1/Gamma/Pi2 unless this is the closing half-round.
// Decrypt ordering only exists when NEOKEON_DECRYPT_EN is defined.
module neokeon_round_fn
  import neokeon_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rc_i,
  input  logic         decrypt_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [127:0] rc_word;
  logic [127:0] mixed;

  assign rc_word = {24'h0, rc_i, 96'h0};

`ifndef NEOKEON_DECRYPT_EN
  logic unused_decrypt;
  assign unused_decrypt = decrypt_i;
`endif

  // Linear half-round followed by the optional nonlinear layer.
  always_comb begin
`ifdef NEOKEON_DECRYPT_EN
    if (decrypt_i) mixed = theta(state_i, key_i) ^ rc_word;
    else           mixed = theta(state_i ^ rc_word, key_i);
`else
    mixed = theta(state_i ^ rc_word, key_i);
`endif
    state_o = final_i ? mixed : pi2(gamma(pi1(mixed)));
  end

endmodule

// File: rtl/neokeon_round_engine.sv
// Iterative Noekeon direct-key engine, one round per clock, start/valid/ack handshake.
// Define NEOKEON_DECRYPT_EN to add the decrypt path; otherwise every block encrypts.
module neokeon_round_engine
  import neokeon_pkg::*;
#(
  parameter int unsigned ROUNDS = 16
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inStart,
  input  logic         inDecrypt,
  input  logic [127:0] inDataState,
  input  logic [127:0] inKey,
  input  logic         inAck,
  output logic         outReady,
  output logic         outValid,
  output logic [127:0] outDataState
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_e         st_q;
  logic [127:0]   state_q, key_q, out_q;
  logic [7:0]     rc_q;
  logic           dec_q, valid_q, ready_q;
  logic [CW-1:0]  cnt_q;

  logic [127:0]   rnd_s, key_ld;
  logic [7:0]     rc_ld, rc_step;
  logic           dec_ld, load;

`ifdef NEOKEON_DECRYPT_EN
  localparam logic [7:0] RC_DEC_INIT = rc_at(ROUNDS);
`else
  logic unused_decrypt;
  assign unused_decrypt = inDecrypt;
`endif

  neokeon_round_fn u_round (
    .state_i   (state_q),
    .key_i     (key_q),
    .rc_i      (rc_q),
    .decrypt_i (dec_q),
    .final_i   (st_q == ST_FINAL),
    .state_o   (rnd_s)
  );

  // Load values and the per-round constant step for the selected mode.
  always_comb begin
    load = inStart && ((st_q == ST_IDLE) || ((st_q == ST_DONE) && inAck));
`ifdef NEOKEON_DECRYPT_EN
    dec_ld  = inDecrypt;
    key_ld  = inDecrypt ? theta(inKey, '0) : inKey;
    rc_ld   = inDecrypt ? RC_DEC_INIT : NEOKEON_RC_INIT;
    rc_step = dec_q ? rc_prev(rc_q) : rc_next(rc_q);
`else
    dec_ld  = 1'b0;
    key_ld  = inKey;
    rc_ld   = NEOKEON_RC_INIT;
    rc_step = rc_next(rc_q);
`endif
  end

  // Control FSM with registered handshake outputs; a load overrides the per-state
  // update so IDLE starts and DONE back-to-back starts share one path.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      dec_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (st_q)
        ST_IDLE: ;
        ST_ROUND: begin
          state_q <= rnd_s;
          rc_q    <= rc_step;
          if (cnt_q == LAST) st_q <= ST_FINAL;
          else               cnt_q <= cnt_q + CW'(1);
        end
        ST_FINAL: begin
          out_q   <= rnd_s;
          valid_q <= 1'b1;
          st_q    <= ST_DONE;
        end
        ST_DONE: begin
          if (inAck) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            st_q    <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
      if (load) begin
        state_q <= inDataState;
        key_q   <= key_ld;
        rc_q    <= rc_ld;
        dec_q   <= dec_ld;
        cnt_q   <= '0;
        ready_q <= 1'b0;
        st_q    <= ST_ROUND;
      end
    end
  end

  assign outReady     = ready_q;
  assign outValid     = valid_q;
  assign outDataState = out_q;

endmodule

// File: tb/tb_neokeon_round_engine.sv
// Scoreboard bench for neokeon_round_engine (ROUNDS=16 main instance, ROUNDS=1 second instance).
// Decrypt vectors run only when NEOKEON_DECRYPT_EN is defined.
module tb_neokeon_round_engine;

  localparam logic [127:0] VEC_ZERO_CT = 128'hb1656851699e29fa24b70148503d2dfc;
  localparam logic [127:0] KEY_ONES    = {128{1'b1}};
  localparam logic [127:0] PT_B        = 128'h6954e6d2713150fa99d8dc6fd246cddc;
  localparam logic [127:0] KEY_C       = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT_C        = 128'hdeadbeef00112233cafef00d55aa55aa;

  logic         inClk = 1'b0;
  logic         inRstN, inStart, inDecrypt, inAck;
  logic [127:0] inDataState, inKey;
  logic         outReady, outValid;
  logic [127:0] outDataState;

  logic         r1_start, r1_ack;
  logic [127:0] r1_data, r1_key;
  logic         r1_ready, r1_valid;
  logic [127:0] r1_out;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic [127:0] exp1_q[$];
  int           acc1_q[$];

  always #5 inClk = ~inClk;

  neokeon_round_engine #(.ROUNDS(16)) dut (
    .inClk(inClk), .inRstN(inRstN), .inStart(inStart), .inDecrypt(inDecrypt),
    .inDataState(inDataState), .inKey(inKey), .inAck(inAck),
    .outReady(outReady), .outValid(outValid), .outDataState(outDataState)
  );

  neokeon_round_engine #(.ROUNDS(1)) dut_r1 (
    .inClk(inClk), .inRstN(inRstN), .inStart(r1_start), .inDecrypt(1'b0),
    .inDataState(r1_data), .inKey(r1_key), .inAck(r1_ack),
    .outReady(r1_ready), .outValid(r1_valid), .outDataState(r1_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model (word-serial, as in the cipher description)
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] m_theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
    t = a[0] ^ a[2]; t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] ^= t; a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[127-32*i -: 32];
    t = a[1] ^ a[3]; t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] ^= t; a[2] ^= t;
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] m_gamma(input logic [127:0] s);
    logic [31:0] a[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] m_pi(input logic [127:0] s, input bit second);
    if (!second) return {s[127:96], rl(s[95:64], 1), rl(s[63:32], 5), rl(s[31:0], 2)};
    return {s[127:96], rl(s[95:64], 31), rl(s[63:32], 27), rl(s[31:0], 30)};
  endfunction

  function automatic logic [127:0] ref_enc(input int rounds, input logic [127:0] k, input logic [127:0] d);
    logic [127:0] s;
    logic [7:0]   rc;
    s  = d;
    rc = 8'h80;
    for (int r = 0; r < rounds; r++) begin
      s[103:96] = s[103:96] ^ rc;
      s = m_pi(m_gamma(m_pi(m_theta(s, k), 1'b0)), 1'b1);
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    end
    s[103:96] = s[103:96] ^ rc;
    return m_theta(s, k);
  endfunction

  // ---------------- acceptance capture (cycle count after the accepting edge)
  always @(posedge inClk) begin
    cyc <= cyc + 1;
    if (inRstN && inStart && (outReady || (outValid && inAck))) acc_q.push_back(cyc + 1);
    if (inRstN && r1_start && (r1_ready || (r1_valid && r1_ack))) acc1_q.push_back(cyc + 1);
  end

  // ---------------- monitors: pop and compare on every new result
  logic         vprev = 1'b0, vprev1 = 1'b0;
  logic [127:0] m_exp, m_exp1;
  int           m_acc, m_acc1;

  always @(negedge inClk) begin
    if (!inRstN) vprev = 1'b0;
    else begin
      if (outValid && !vprev) begin
        if (exp_q.size() == 0) chk("unexpected_valid", outValid, 0);
        else begin
          m_exp = exp_q.pop_front();
          chk("result", outDataState, m_exp);
          if (acc_q.size() == 0) chk("accept_seen", 0, 1);
          else begin
            m_acc = acc_q.pop_front();
            chk("latency", cyc - m_acc, 17);
          end
        end
      end
      vprev = outValid;
    end
  end

  always @(negedge inClk) begin
    if (!inRstN) vprev1 = 1'b0;
    else begin
      if (r1_valid && !vprev1) begin
        if (exp1_q.size() == 0) chk("r1_unexpected_valid", r1_valid, 0);
        else begin
          m_exp1 = exp1_q.pop_front();
          chk("r1_result", r1_out, m_exp1);
          if (acc1_q.size() == 0) chk("r1_accept_seen", 0, 1);
          else begin
            m_acc1 = acc1_q.pop_front();
            chk("r1_latency", cyc - m_acc1, 2);
          end
        end
      end
      vprev1 = r1_valid;
    end
  end

  // ---------------- stimulus helpers (drive at negedge)
  task automatic wait_ready();
    for (int i = 0; i < 60 && !outReady; i++) @(negedge inClk);
    if (!outReady) chk("ready_timeout", outReady, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !outValid; i++) @(negedge inClk);
    if (!outValid) chk("valid_timeout", outValid, 1);
  endtask

  task automatic issue(input logic dec, input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] e);
    exp_q.push_back(e);
    inDecrypt = dec; inKey = k; inDataState = d; inStart = 1'b1;
    @(negedge inClk);
    inStart = 1'b0;
    // Scramble inputs after acceptance; the running block must not notice.
    inDecrypt = ~dec; inKey = ~k; inDataState = ~d;
  endtask

  task automatic do_ack();
    inAck = 1'b1;
    @(negedge inClk);
    inAck = 1'b0;
    chk("ack_valid_low", outValid, 0);
    chk("ack_ready_high", outReady, 1);
  endtask

  task automatic r1_run(input logic [127:0] k, input logic [127:0] d);
    for (int i = 0; i < 20 && !r1_ready; i++) @(negedge inClk);
    exp1_q.push_back(ref_enc(1, k, d));
    r1_key = k; r1_data = d; r1_start = 1'b1;
    @(negedge inClk);
    r1_start = 1'b0; r1_key = ~k; r1_data = ~d;
    for (int i = 0; i < 20 && !r1_valid; i++) @(negedge inClk);
    if (!r1_valid) chk("r1_valid_timeout", r1_valid, 1);
    r1_ack = 1'b1;
    @(negedge inClk);
    r1_ack = 1'b0;
    chk("r1_ack_ready", r1_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    inRstN = 1'b1; inStart = 1'b0; inDecrypt = 1'b0; inAck = 1'b0;
    inDataState = '0; inKey = '0;
    r1_start = 1'b0; r1_ack = 1'b0; r1_data = '0; r1_key = '0;
    #2 inRstN = 1'b0;
    #2;
    chk("rst_valid", outValid, 0);
    chk("rst_ready", outReady, 1);
    chk("rst_data", outDataState, 0);
    repeat (2) @(negedge inClk);
    inRstN = 1'b1;
    @(negedge inClk);

    // Zero key / zero data vector, then hold the result without ack.
    wait_ready();
    issue(1'b0, '0, '0, VEC_ZERO_CT);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge inClk);
      chk("hold_valid", outValid, 1);
      chk("hold_data", outDataState, VEC_ZERO_CT);
    end
    do_ack();
    chk("idle_keeps_result", outDataState, VEC_ZERO_CT);

    // All-ones key; a start pulse during ROUND must be ignored.
    wait_ready();
    issue(1'b0, KEY_ONES, PT_B, ref_enc(16, KEY_ONES, PT_B));
    repeat (3) @(negedge inClk);
    inStart = 1'b1; inDataState = PT_C; inKey = KEY_C;
    @(negedge inClk);
    inStart = 1'b0;
    wait_valid();

    // Back-to-back: ack and start together in DONE.
    inAck = 1'b1;
    issue(1'b0, KEY_C, PT_C, ref_enc(16, KEY_C, PT_C));
    inAck = 1'b0;
    chk("b2b_valid_drop", outValid, 0);
    chk("b2b_ready_low", outReady, 0);
    wait_valid();
    do_ack();

    // Asynchronous reset mid-ROUND (count = 7), then a fresh block.
    wait_ready();
    issue(1'b0, KEY_C, PT_B, 128'h0);
    repeat (7) @(negedge inClk);
    #2 inRstN = 1'b0;
    #1;
    chk("midrst_valid", outValid, 0);
    chk("midrst_ready", outReady, 1);
    chk("midrst_data", outDataState, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge inClk);
    inRstN = 1'b1;
    @(negedge inClk);
    wait_ready();
    issue(1'b0, '0, '0, VEC_ZERO_CT);
    wait_valid();
    do_ack();

`ifdef NEOKEON_DECRYPT_EN
    wait_ready();
    issue(1'b1, '0, VEC_ZERO_CT, '0);
    wait_valid();
    do_ack();
    wait_ready();
    issue(1'b1, KEY_ONES, ref_enc(16, KEY_ONES, PT_B), PT_B);
    wait_valid();
    do_ack();
`endif

    // Single-round instance.
    r1_run('0, '0);
    r1_run(KEY_C, PT_C);

    repeat (3) @(negedge inClk);
    chk("scoreboard_drained", exp_q.size() + exp1_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
